// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_XFER  = 2'b10
  } arb_state_e;

  localparam int unsigned XFER_CNT_W = 16;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer streams plus the FIFO write port, as seen by the arbiter.
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WORD_LENGTH = 8
);

  logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [WORD_LENGTH-1:0]         fifo_data_in;
  logic                           fifo_data_in_valid;
  logic                           fifo_ready_in;

  // Arbiter side
  modport slave (
    input  req_data, req_valid, fifo_ready_in,
    output req_ready, fifo_data_in, fifo_data_in_valid
  );

  // Producers and FIFO side
  modport master (
    output req_data, req_valid, fifo_ready_in,
    input  req_ready, fifo_data_in, fifo_data_in_valid
  );

endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// Rotating-priority search: first set req bit after 'last', wrapping.
module rr_priority_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned GID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last,
  output logic [GID_W-1:0]   pick,
  output logic               any
);

  logic [GID_W-1:0] idx;

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); keep the first hit.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = GID_W'((32'(last) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned WORD_LENGTH = 8,
  localparam int unsigned GID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_write_arbiter_if.slave   bus,
  output logic [GID_W-1:0]      grant_id,
  output logic                  busy,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  arb_state_e             state_q, state_d;
  logic [GID_W-1:0]       grant_d;
  logic [GID_W-1:0]       last_q, last_d;
  logic [XFER_CNT_W-1:0]  cnt_d;
  logic [GID_W-1:0]       pick;
  logic                   pick_any;
  logic                   sel_valid;
  logic [WORD_LENGTH-1:0] sel_data;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req  (bus.req_valid),
    .last (last_q),
    .pick (pick),
    .any  (pick_any)
  );

  assign sel_valid = bus.req_valid[grant_id];
  assign sel_data  = bus.req_data[grant_id*WORD_LENGTH +: WORD_LENGTH];

  // State, grant, priority pointer and word counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_id   <= '0;
      last_q     <= GID_W'(NUM_REQ - 1);
      xfer_count <= '0;
    end else begin
      state_q    <= state_d;
      grant_id   <= grant_d;
      last_q     <= last_d;
      xfer_count <= cnt_d;
    end
  end

  // Next-state and handshake routing; last_q only moves after a completed word.
  always_comb begin
    state_d                = state_q;
    grant_d                = grant_id;
    last_d                 = last_q;
    cnt_d                  = xfer_count;
    bus.req_ready          = '0;
    bus.fifo_data_in       = '0;
    bus.fifo_data_in_valid = 1'b0;
    busy                   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.fifo_ready_in && pick_any) begin
          grant_d = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        busy                    = 1'b1;
        bus.fifo_data_in        = sel_data;
        bus.fifo_data_in_valid  = sel_valid;
        bus.req_ready[grant_id] = bus.fifo_ready_in;
        if (!sel_valid) begin
          state_d = ST_IDLE;
        end else if (bus.fifo_ready_in) begin
          cnt_d   = xfer_count + 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        busy                   = 1'b1;
        bus.fifo_data_in       = sel_data;
        bus.fifo_data_in_valid = sel_valid;
        if (!sel_valid) begin
          last_d  = grant_id;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus corner sequences.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] xfer_count;

  int tests;
  int fails;

  logic [7:0] fifo_q[$];

  fifo_write_arbiter_if #(.NUM_REQ(4), .WORD_LENGTH(8)) bus ();

  fifo_write_arbiter #(.NUM_REQ(4), .WORD_LENGTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: a word is written when the granted producer's handshake completes.
  always @(posedge clk) begin
    if (!reset && |(bus.req_ready & bus.req_valid))
      fifo_q.push_back(bus.fifo_data_in);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  rr;
    logic        fv;
    logic [7:0]  data;
    logic [1:0]  gid;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    @(negedge clk);
    bus.req_valid     = v;
    bus.fifo_ready_in = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    fifo_q.delete();
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Round-robin with every producer re-requesting one cycle after its word.
    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0};
    vecs[1]  = '{4'b1111, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 16'd0};
    vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1, 16'd1};
    vecs[3]  = '{4'b1110, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1, 16'd1};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd1};
    vecs[5]  = '{4'b1111, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1, 16'd1};
    vecs[6]  = '{4'b1101, 4'b0000, 1'b0, 8'h11, 2'd1, 1'b1, 16'd2};
    vecs[7]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0, 16'd2};
    vecs[8]  = '{4'b1111, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1, 16'd2};
    vecs[9]  = '{4'b1011, 4'b0000, 1'b0, 8'h12, 2'd2, 1'b1, 16'd3};
    vecs[10] = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0, 16'd3};
    vecs[11] = '{4'b1111, 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1, 16'd3};
    vecs[12] = '{4'b0111, 4'b0000, 1'b0, 8'h13, 2'd3, 1'b1, 16'd4};
    vecs[13] = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0, 16'd4};
    vecs[14] = '{4'b1111, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 16'd4};

    // Reset held with every producer requesting.
    reset             = 1'b1;
    bus.req_valid     = 4'b1111;
    bus.req_data      = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.fifo_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset%0d.req_ready", i), 32'(bus.req_ready), 32'h0);
      chk($sformatf("reset%0d.valid", i), 32'(bus.fifo_data_in_valid), 32'h0);
      chk($sformatf("reset%0d.grant_id", i), 32'(grant_id), 32'h0);
      chk($sformatf("reset%0d.xfer_count", i), 32'(xfer_count), 32'h0);
    end

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      reset             = 1'b0;
      bus.req_valid     = vecs[i].valid;
      bus.fifo_ready_in = 1'b1;
      #1;
      chk($sformatf("rr%0d.req_ready", i), 32'(bus.req_ready), 32'(vecs[i].rr));
      chk($sformatf("rr%0d.valid", i), 32'(bus.fifo_data_in_valid), 32'(vecs[i].fv));
      chk($sformatf("rr%0d.data", i), 32'(bus.fifo_data_in), 32'(vecs[i].data));
      chk($sformatf("rr%0d.grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
      chk($sformatf("rr%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("rr%0d.xfer_count", i), 32'(xfer_count), 32'(vecs[i].cnt));
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("rr.fifo_words", 32'(fifo_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr.fifo_word%0d", i),
          (i < fifo_q.size()) ? 32'(fifo_q[i]) : 32'hDEAD, 32'h10 + 32'(i % 4));

    // Single producer, two words separated by a low cycle.
    do_reset();
    bus.req_data[23:16] = 8'hA5;
    step(4'b0100, 1'b1);
    chk("single.idle_busy", 32'(busy), 32'h0);
    step(4'b0100, 1'b1);
    chk("single.w0_ready", 32'(bus.req_ready), 32'h4);
    chk("single.w0_data", 32'(bus.fifo_data_in), 32'hA5);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    bus.req_data[23:16] = 8'h3C;
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    chk("single.w1_ready", 32'(bus.req_ready), 32'h4);
    chk("single.w1_data", 32'(bus.fifo_data_in), 32'h3C);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("single.xfer_count", 32'(xfer_count), 32'd2);
    chk("single.grant_id", 32'(grant_id), 32'd2);
    chk("single.fifo_words", 32'(fifo_q.size()), 32'd2);
    chk("single.fifo_word0", (fifo_q.size() > 0) ? 32'(fifo_q[0]) : 32'hDEAD, 32'hA5);
    chk("single.fifo_word1", (fifo_q.size() > 1) ? 32'(fifo_q[1]) : 32'hDEAD, 32'h3C);

    // FIFO full: no grant until ready rises, then producer 1 first.
    do_reset();
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    step(4'b1010, 1'b0);
    chk("full0.busy", 32'(busy), 32'h0);
    chk("full0.req_ready", 32'(bus.req_ready), 32'h0);
    step(4'b1010, 1'b0);
    chk("full1.busy", 32'(busy), 32'h0);
    chk("full1.req_ready", 32'(bus.req_ready), 32'h0);
    chk("full1.xfer_count", 32'(xfer_count), 32'h0);
    step(4'b1010, 1'b1);
    chk("full2.busy", 32'(busy), 32'h0);
    step(4'b1010, 1'b1);
    chk("full3.grant_id", 32'(grant_id), 32'd1);
    chk("full3.req_ready", 32'(bus.req_ready), 32'h2);
    chk("full3.data", 32'(bus.fifo_data_in), 32'h11);
    step(4'b1000, 1'b1);
    chk("full4.xfer_count", 32'(xfer_count), 32'd1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    chk("full6.grant_id", 32'(grant_id), 32'd3);
    chk("full6.req_ready", 32'(bus.req_ready), 32'h8);

    // Withdrawal while the FIFO stalls keeps producer 0's priority.
    do_reset();
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    chk("wd.hold_busy", 32'(busy), 32'h1);
    chk("wd.hold_req_ready", 32'(bus.req_ready), 32'h0);
    chk("wd.hold_valid", 32'(bus.fifo_data_in_valid), 32'h1);
    step(4'b0000, 1'b0);
    chk("wd.drop_valid", 32'(bus.fifo_data_in_valid), 32'h0);
    step(4'b0011, 1'b1);
    chk("wd.idle_busy", 32'(busy), 32'h0);
    chk("wd.xfer_count", 32'(xfer_count), 32'h0);
    chk("wd.fifo_words", 32'(fifo_q.size()), 32'h0);
    step(4'b0011, 1'b1);
    chk("wd.regrant_id", 32'(grant_id), 32'd0);
    chk("wd.regrant_ready", 32'(bus.req_ready), 32'h1);

    // Reset while XFER with valid still high.
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    chk("rx.grant_ready", 32'(bus.req_ready), 32'h2);
    step(4'b0010, 1'b1);
    chk("rx.xfer_busy", 32'(busy), 32'h1);
    chk("rx.xfer_valid", 32'(bus.fifo_data_in_valid), 32'h1);
    chk("rx.xfer_count", 32'(xfer_count), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    chk("rx.after_busy", 32'(busy), 32'h0);
    chk("rx.after_valid", 32'(bus.fifo_data_in_valid), 32'h0);
    chk("rx.after_count", 32'(xfer_count), 32'h0);
    chk("rx.after_grant_id", 32'(grant_id), 32'h0);
    step(4'b0011, 1'b1);
    chk("rx.next_grant_id", 32'(grant_id), 32'd0);
    chk("rx.next_req_ready", 32'(bus.req_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
